// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths and issue-latency selection for the decode hazard scoreboard.
package hazard_pkg;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int tmr_w(input int wb_lat);
        return (wb_lat > 0) ? $clog2(wb_lat + 1) : 1;
    endfunction
    // Cycles until a freshly issued result is visible to decode.
    function automatic int lat_sel(input bit fwd_en, input bit is_load, input int wb_lat, input int load_lat);
        return fwd_en ? (is_load ? load_lat : 0) : wb_lat;
    endfunction
endpackage

// File: rtl/hazard_reg_timer.sv
// hazard_reg_timer: per-register countdown of cycles until its pending write is readable.
module hazard_reg_timer #(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          busy
);
    logic [TW-1:0] cnt_d, cnt_q;
    assign busy = cnt_q != '0;
    always_comb cnt_d = load ? load_val : (busy ? cnt_q - TW'(1) : cnt_q);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage RAW stall generation from per-register write timers,
// with a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int WB_LAT   = 3,
    parameter int FWD_EN   = 0,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [idx_w(NUM_REGS)-1:0]    id_rs,
    input  logic                          id_rs_vld,
    input  logic [idx_w(NUM_REGS)-1:0]    id_rt,
    input  logic                          id_rt_vld,
    input  logic [idx_w(NUM_REGS)-1:0]    id_rd,
    input  logic                          id_rd_vld,
    input  logic                          id_is_load,
    input  logic                          flush,
    output logic                          stall,
    output logic [CNT_W-1:0]              stall_cycles
);
    localparam int TW = tmr_w(WB_LAT);
    logic [NUM_REGS-1:0] busy, load;
    logic [TW-1:0]       load_val;
    logic                issue;
    logic [CNT_W-1:0]    stall_cycles_d, stall_cycles_q;
    always_comb begin
        stall          = id_valid && !flush && ((id_rs_vld && busy[id_rs]) || (id_rt_vld && busy[id_rt]));
        issue          = id_valid && !flush && !stall && id_rd_vld;
        load_val       = TW'(lat_sel(FWD_EN != 0, id_is_load, WB_LAT, LOAD_LAT));
        load           = issue ? (NUM_REGS'(1) << id_rd) : '0;
        stall_cycles_d = (stall && stall_cycles_q != '1) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
    end
    // A new writer reloads its register's timer, overriding any older pending write.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_tmr
        hazard_reg_timer #(.TW(TW)) u_tmr (
            .clk      (clk),
            .rst      (rst),
            .load     (load[g]),
            .load_val (load_val),
            .busy     (busy[g])
        );
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cycles_q <= '0;
        else      stall_cycles_q <= stall_cycles_d;
    end
    assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors drive two scoreboard configurations; expected
// stall/stall_cycles are queued per cycle and checked by an independent monitor.
module tb_hazard_scoreboard;
    logic        clk, rst;
    logic        id_valid, id_rs_vld, id_rt_vld, id_rd_vld, id_is_load, flush;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic        stall0, stall1;
    logic [3:0]  sc0;
    logic [15:0] sc1;
    int          checks = 0;
    int          fails  = 0;
    typedef struct {
        string nm;
        int    sel;
        logic  es;
        int    ec;
    } exp_t;
    exp_t q[$];

    hazard_scoreboard #(.NUM_REGS(8), .WB_LAT(3), .FWD_EN(0), .LOAD_LAT(1), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_vld(id_rs_vld),
        .id_rt(id_rt), .id_rt_vld(id_rt_vld), .id_rd(id_rd), .id_rd_vld(id_rd_vld),
        .id_is_load(id_is_load), .flush(flush), .stall(stall0), .stall_cycles(sc0)
    );
    hazard_scoreboard #(.NUM_REGS(8), .WB_LAT(3), .FWD_EN(1), .LOAD_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_vld(id_rs_vld),
        .id_rt(id_rt), .id_rt_vld(id_rt_vld), .id_rd(id_rd), .id_rd_vld(id_rd_vld),
        .id_is_load(id_is_load), .flush(flush), .stall(stall1), .stall_cycles(sc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin : mon
        exp_t e;
        logic as;
        int   ac;
        if (q.size() > 0) begin
            e  = q.pop_front();
            as = (e.sel == 0) ? stall0 : stall1;
            ac = (e.sel == 0) ? int'(sc0) : int'(sc1);
            checks++;
            if (as !== e.es) begin
                fails++;
                $display("FAIL %s dut%0d stall: got %b expected %b", e.nm, e.sel, as, e.es);
            end
            checks++;
            if (ac != e.ec) begin
                fails++;
                $display("FAIL %s dut%0d stall_cycles: got %0d expected %0d", e.nm, e.sel, ac, e.ec);
            end
        end
    end

    task automatic cyc(input string nm, input int sel, input bit v, input int rs, input bit rsv,
                       input int rt, input bit rtv, input int rd, input bit rdv, input bit ld,
                       input bit fl, input bit es, input int ec);
        exp_t e;
        id_valid = v; id_rs = 3'(rs); id_rs_vld = rsv; id_rt = 3'(rt); id_rt_vld = rtv;
        id_rd = 3'(rd); id_rd_vld = rdv; id_is_load = ld; flush = fl;
        e.nm = nm; e.sel = sel; e.es = es; e.ec = ec;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input string nm, input int sel, input int rd, input bit ld, input int ec);
        cyc(nm, sel, 1, 0, 0, 0, 0, rd, 1, ld, 0, 0, ec);
    endtask
    task automatic rd_rs(input string nm, input int sel, input int rs, input bit es, input int ec);
        cyc(nm, sel, 1, rs, 1, 0, 0, 0, 0, 0, 0, es, ec);
    endtask
    task automatic nop(input string nm, input int sel, input int ec);
        cyc(nm, sel, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ec);
    endtask
    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int sc;
        rst = 1'b0;
        id_valid = 0; id_rs = 0; id_rs_vld = 0; id_rt = 0; id_rt_vld = 0;
        id_rd = 0; id_rd_vld = 0; id_is_load = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        // Reset state, then asynchronous reset while r2 is pending.
        nop("rst_state", 0, 0);
        rd_rs("rst_rd", 0, 5, 0, 0);
        wr("mid_wr", 0, 2, 0, 0);
        rd_rs("mid_stall", 0, 2, 1, 0);
        rst = 1'b0;
        rd_rs("mid_rst", 0, 2, 0, 0);
        rst = 1'b1;
        rd_rs("mid_rel", 0, 2, 0, 0);
        // RAW without forwarding.
        do_reset();
        wr("raw_wr", 0, 1, 0, 0);
        cyc("raw_stall1", 0, 1, 1, 1, 0, 0, 2, 1, 0, 0, 1, 0);
        cyc("raw_stall2", 0, 1, 1, 1, 0, 0, 2, 1, 0, 0, 1, 1);
        cyc("raw_stall3", 0, 1, 1, 1, 0, 0, 2, 1, 0, 0, 1, 2);
        cyc("raw_issue", 0, 1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 3);
        cyc("raw_issued", 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 3);
        nop("raw_nop", 0, 4);
        wr("late_wr", 0, 3, 0, 4);
        nop("late_nop1", 0, 4);
        nop("late_nop2", 0, 4);
        nop("late_nop3", 0, 4);
        rd_rs("late_dep", 0, 3, 0, 4);
        cyc("self_rd", 0, 1, 6, 1, 0, 0, 6, 1, 0, 0, 0, 4);
        cyc("self_pend", 0, 1, 6, 1, 0, 0, 6, 1, 0, 0, 1, 4);
        // Overwrite and independence.
        do_reset();
        wr("ow_w4", 0, 4, 0, 0);
        wr("ow_w5", 0, 5, 0, 0);
        rd_rs("ow_r4a", 0, 4, 1, 0);
        rd_rs("ow_r4b", 0, 4, 1, 1);
        cyc("ow_r45", 0, 1, 4, 1, 5, 1, 0, 0, 0, 0, 1, 2);
        cyc("ow_r45_done", 0, 1, 4, 1, 5, 1, 0, 0, 0, 0, 0, 3);
        wr("re_w4a", 0, 4, 0, 3);
        nop("re_nop", 0, 3);
        wr("re_w4b", 0, 4, 0, 3);
        rd_rs("re_st1", 0, 4, 1, 3);
        rd_rs("re_st2", 0, 4, 1, 4);
        rd_rs("re_st3", 0, 4, 1, 5);
        rd_rs("re_done", 0, 4, 0, 6);
        // Flush beats stall, suppresses issue, and timers keep running.
        do_reset();
        wr("fl_wr", 0, 1, 0, 0);
        cyc("fl_hazard", 0, 1, 1, 1, 0, 0, 2, 1, 0, 1, 0, 0);
        rd_rs("fl_noissue", 0, 2, 0, 0);
        rd_rs("fl_dec", 0, 1, 1, 0);
        rd_rs("fl_done", 0, 1, 0, 1);
        // Saturation of the 4-bit stall counter.
        sc = 1;
        for (int k = 0; k < 6; k++) begin
            wr("sat_wr", 0, 7, 0, (sc > 15) ? 15 : sc);
            for (int j = 0; j < 3; j++) begin
                rd_rs("sat_stall", 0, 7, 1, (sc > 15) ? 15 : sc);
                sc++;
            end
        end
        rd_rs("sat_hold", 0, 7, 0, 15);
        // Forwarding configuration.
        do_reset();
        wr("fw_alu", 1, 1, 0, 0);
        rd_rs("fw_alu_use", 1, 1, 0, 0);
        wr("fw_ld", 1, 3, 1, 0);
        cyc("fw_ld_use", 1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0);
        cyc("fw_ld_done", 1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1);
        wr("fw_ld2", 1, 3, 1, 1);
        cyc("fw_same_src", 1, 1, 3, 1, 3, 1, 0, 0, 0, 0, 1, 1);
        cyc("fw_same_done", 1, 1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 2);
        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
